// File: rtl/cos_range_reduce.sv
// Argument reduction for the Taylor cosine core: maps a signed Q.10 angle into [0, pi/2] plus a negate flag.
// Optional quadrant output is enabled by defining RR_QUAD_OUT_EN.
module cos_range_reduce #(
    parameter int W         = 24,
    parameter int PI_Q      = 3217,
    parameter int HALF_PI_Q = 1608,
    parameter int TWO_PI_Q  = 6434,
    parameter int SHIFT_MAX = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] angle_in,
    output logic         ready_out,
    output logic [W-1:0] angle_out,
    output logic         neg_out
`ifdef RR_QUAD_OUT_EN
    ,
    output logic [1:0]   quad_out
`endif
);

    localparam int KW = $clog2(SHIFT_MAX + 1);
    localparam logic [W:0]   TWO_PI_EXT = (W+1)'(TWO_PI_Q);
    localparam logic [W-1:0] TWO_PI_W   = W'(TWO_PI_Q);
    localparam logic [W-1:0] PI_W       = W'(PI_Q);
    localparam logic [W-1:0] HALF_W     = W'(HALF_PI_Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_REDUCE,
        S_FOLD1,
        S_FOLD2,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_angle;
    logic [W-1:0]    r_mag;
    logic [KW-1:0]   r_k;
`ifdef RR_QUAD_OUT_EN
    logic            r_hi;
`endif

    logic [W-1:0]    w_abs;
    logic [W:0]      w_step;
    logic [W:0]      w_diff;
    logic            w_ge;

    // Negating -2^(W-1) wraps back to 2^(W-1), which is the correct magnitude read as unsigned.
    assign w_abs  = r_angle[W-1] ? -r_angle : r_angle;
    assign w_step = TWO_PI_EXT << r_k;
    assign w_diff = {1'b0, r_mag} - w_step;
    assign w_ge   = ~w_diff[W];

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_angle   <= '0;
            r_mag     <= '0;
            r_k       <= '0;
            ready_out <= 1'b0;
            angle_out <= '0;
            neg_out   <= 1'b0;
`ifdef RR_QUAD_OUT_EN
            r_hi      <= 1'b0;
            quad_out  <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_angle <= angle_in;
                        r_state <= S_ABS;
                    end
                end
                S_ABS: begin
                    r_mag   <= w_abs;
                    r_k     <= KW'(SHIFT_MAX);
                    r_state <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (w_ge) begin
                        r_mag <= w_diff[W-1:0];
                    end
                    if (r_k == '0) begin
                        r_state <= S_FOLD1;
                    end else begin
                        r_k <= r_k - KW'(1);
                    end
                end
                S_FOLD1: begin
                    // cos is even about pi: fold the upper half-turn back onto [0, pi].
                    if (r_mag >= PI_W) begin
                        r_mag <= TWO_PI_W - r_mag;
`ifdef RR_QUAD_OUT_EN
                        r_hi  <= 1'b1;
                    end else begin
                        r_hi  <= 1'b0;
`endif
                    end
                    r_state <= S_FOLD2;
                end
                S_FOLD2: begin
                    if (r_mag > HALF_W) begin
                        angle_out <= PI_W - r_mag;
                        neg_out   <= 1'b1;
`ifdef RR_QUAD_OUT_EN
                        quad_out  <= r_hi ? 2'd2 : 2'd1;
`endif
                    end else begin
                        angle_out <= r_mag;
                        neg_out   <= 1'b0;
`ifdef RR_QUAD_OUT_EN
                        quad_out  <= r_hi ? 2'd3 : 2'd0;
`endif
                    end
                    ready_out <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (!start) begin
                        ready_out <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_range_reduce.sv
// Scoreboard bench for cos_range_reduce: driver pushes model results, a negedge monitor pops and compares.
module tb_cos_range_reduce;

    localparam int W         = 24;
    localparam int PI_Q      = 3217;
    localparam int HALF_PI_Q = 1608;
    localparam int TWO_PI_Q  = 6434;
    localparam int LATENCY   = 15;

    typedef struct {
        logic [W-1:0] ang;
        logic         neg;
        logic [1:0]   quad;
        int           cyc;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] angle_in;
    logic         ready_out;
    logic [W-1:0] angle_out;
    logic         neg_out;
`ifdef RR_QUAD_OUT_EN
    logic [1:0]   quad_out;
`endif

    cos_range_reduce dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .angle_in  (angle_in),
        .ready_out (ready_out),
        .angle_out (angle_out),
        .neg_out   (neg_out)
`ifdef RR_QUAD_OUT_EN
        ,
        .quad_out  (quad_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_ready = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Plain-arithmetic reference: |a| mod 2pi, then fold about pi and pi/2.
    function automatic exp_t model(input logic [W-1:0] a);
        exp_t   e;
        longint v, mag, r0, r1;
        logic   hi;
        v   = longint'($signed(a));
        mag = (v < 0) ? -v : v;
        r0  = mag % TWO_PI_Q;
        hi  = (r0 >= PI_Q);
        r1  = hi ? (TWO_PI_Q - r0) : r0;
        if (r1 > HALF_PI_Q) begin
            e.ang  = W'(PI_Q - r1);
            e.neg  = 1'b1;
            e.quad = hi ? 2'd2 : 2'd1;
        end else begin
            e.ang  = W'(r1);
            e.neg  = 1'b0;
            e.quad = hi ? 2'd3 : 2'd0;
        end
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clock) begin
        if (ready_out && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("angle_out", angle_out, mon_e.ang);
                check("neg_out", neg_out, mon_e.neg);
                check("latency", cyc, mon_e.cyc);
`ifdef RR_QUAD_OUT_EN
                check("quad_out", quad_out, mon_e.quad);
`endif
            end
        end
        prev_ready <= ready_out;
    end

    task automatic run_one(input logic [W-1:0] a, input int hold);
        exp_t e;
        int   n;
        e = model(a);
        @(negedge clock);
        angle_in = a;
        start    = 1'b1;
        @(negedge clock);
        e.cyc = cyc + LATENCY;
        sb.push_back(e);
        angle_in = W'($urandom);
        n = 0;
        while (!ready_out && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!ready_out) begin
            check("ready_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        for (int h = 0; h < hold; h++) begin
            angle_in = W'($urandom);
            @(negedge clock);
            check("hold_ready", ready_out, 1);
            check("hold_angle", angle_out, e.ang);
        end
        start = 1'b0;
        @(negedge clock);
        check("drop_ready", ready_out, 0);
        check("keep_angle", angle_out, e.ang);
        check("keep_neg", neg_out, e.neg);
    endtask

    initial begin
        logic [W-1:0] dir[$];
        reset    = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(negedge clock);
        check("reset_ready", ready_out, 0);
        check("reset_angle", angle_out, 0);
        check("reset_neg", neg_out, 0);
        reset = 1'b0;

        run_one(W'(1024), 3);
        dir = '{W'(2048), W'(4096), W'(-1024), W'(7458), W'(3217), W'(0),
                W'(6434 * 5), W'(1608), W'(1609), W'(6434 + 3217),
                24'h800000, 24'h7FFFFF};
        foreach (dir[i]) run_one(dir[i], 0);

        // Abort a run in the middle of the modulo loop.
        run_one(W'(4096), 0);
        @(negedge clock);
        angle_in = W'(2048);
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_ready", ready_out, 0);
        check("midrun_reset_angle", angle_out, 0);
        check("midrun_reset_neg", neg_out, 0);
        reset = 1'b0;
        run_one(W'(2048), 0);

        for (int i = 0; i < 30; i++) run_one(W'($urandom), i % 3);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
